// File: rtl/fft_bitrev_reorder.sv
// Reorders bit-reversed 8-point FFT output into natural order via a ping-pong buffer.
// Optional `FFT_REORDER_SOF_EN adds in_sof framing resync and an error_drop pulse.
module fft_bitrev_reorder #(
  parameter int N     = 8,
  parameter int LOG2N = 3,
  parameter int W     = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
`ifdef FFT_REORDER_SOF_EN
  input  logic                    in_sof,
  output logic                    error_drop,
`endif
  input  logic signed [W-1:0]     x_r,
  input  logic signed [W-1:0]     x_i,
  output logic signed [W-1:0]     X_r,
  output logic signed [W-1:0]     X_i,
  output logic                    out_valid,
  output logic [LOG2N-1:0]        out_idx,
  output logic                    out_sof
);

  typedef enum logic {IDLE, READ} state_t;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

  logic [2*W-1:0]   mem [2][N];
  logic [LOG2N-1:0] wr_cnt;
  logic [LOG2N-1:0] wr_addr;
  logic             wr_bank;
  logic             wr_last;
  logic             sof_hit;
  logic             full_pulse;
  logic             full_bank;

  state_t           state, state_nxt;
  logic [LOG2N-1:0] rd_cnt;
  logic             rd_bank;
  logic             rd_start;
  logic             rd_en;

`ifdef FFT_REORDER_SOF_EN
  assign sof_hit = in_valid && in_sof;
`else
  assign sof_hit = 1'b0;
`endif

  // A resync sample always lands in slot 0, which is its own bit reversal.
  assign wr_addr = sof_hit ? '0 : bitrev(wr_cnt);
  assign wr_last = in_valid && !sof_hit && (wr_cnt == LOG2N'(N-1));

  always_ff @(posedge clk) begin
    if (in_valid) mem[wr_bank][wr_addr] <= {x_r, x_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt     <= '0;
      wr_bank    <= 1'b0;
      full_pulse <= 1'b0;
      full_bank  <= 1'b0;
    end else begin
      full_pulse <= 1'b0;
      if (sof_hit) begin
        wr_cnt <= LOG2N'(1);
      end else if (wr_last) begin
        wr_cnt     <= '0;
        wr_bank    <= ~wr_bank;
        full_pulse <= 1'b1;
        full_bank  <= wr_bank;
      end else if (in_valid) begin
        wr_cnt <= wr_cnt + LOG2N'(1);
      end
    end
  end

`ifdef FFT_REORDER_SOF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) error_drop <= 1'b0;
    else        error_drop <= sof_hit && (wr_cnt != '0);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A frame completing on the last read cycle restarts READ with no bubble.
  always_comb begin
    state_nxt = state;
    rd_start  = 1'b0;
    rd_en     = 1'b0;
    case (state)
      IDLE: begin
        if (full_pulse) begin
          rd_start  = 1'b1;
          state_nxt = READ;
        end
      end
      READ: begin
        rd_en = 1'b1;
        if (rd_cnt == LOG2N'(N-1)) begin
          if (full_pulse) rd_start  = 1'b1;
          else            state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt  <= '0;
      rd_bank <= 1'b0;
    end else if (rd_start) begin
      rd_cnt  <= '0;
      rd_bank <= full_bank;
    end else if (rd_en) begin
      rd_cnt  <= rd_cnt + LOG2N'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      X_r       <= '0;
      X_i       <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_sof   <= 1'b0;
    end else begin
      out_valid <= rd_en;
      out_sof   <= rd_en && (rd_cnt == '0);
      if (rd_en) begin
        {X_r, X_i} <= mem[rd_bank][rd_cnt];
        out_idx    <= rd_cnt;
      end
    end
  end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Randomized bench for fft_bitrev_reorder against a frame-level reorder model.
// Build with FFT_REORDER_SOF_EN defined to also exercise the in_sof resync path.
module tb_fft_bitrev_reorder;

  localparam int N     = 8;
  localparam int LOG2N = 3;
  localparam int W     = 12;

  typedef struct {
    int     re;
    int     im;
    int     idx;
    longint at;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic signed [W-1:0] x_r = '0;
  logic signed [W-1:0] x_i = '0;
  logic signed [W-1:0] X_r;
  logic signed [W-1:0] X_i;
  logic                out_valid;
  logic [LOG2N-1:0]    out_idx;
  logic                out_sof;
`ifdef FFT_REORDER_SOF_EN
  logic                in_sof = 1'b0;
  logic                error_drop;
`endif

  int     vectors = 0;
  int     miscompares = 0;
  longint cyc = 0;
  longint errEdge = -1;
  exp_t   expQ[$];
  int     slotRe[N];
  int     slotIm[N];
  int     frameCnt = 0;
  int     lastRe = 0;
  int     lastIm = 0;
  int     lastIdx = 0;

  fft_bitrev_reorder #(.N(N), .LOG2N(LOG2N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
`ifdef FFT_REORDER_SOF_EN
    .in_sof    (in_sof),
    .error_drop(error_drop),
`endif
    .x_r       (x_r),
    .x_i       (x_i),
    .X_r       (X_r),
    .X_i       (X_i),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_sof   (out_sof)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int revBits(input int a);
    int r = 0;
    for (int i = 0; i < LOG2N; i++) if (((a >> i) & 1) != 0) r |= 1 << (LOG2N - 1 - i);
    return r;
  endfunction

  task automatic checkOutput(input string tag, input longint actual, input longint expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // Drives one cycle of input and feeds the frame model when the sample is valid.
  task automatic applyStimulus(input bit v, input int re, input int im, input bit sof = 1'b0);
    longint e;
    @(posedge clk);
    #1;
    in_valid = v;
    x_r = W'(re);
    x_i = W'(im);
`ifdef FFT_REORDER_SOF_EN
    in_sof = sof;
`endif
    if (v) begin
      e = cyc + 1;
      if (sof) begin
        if (frameCnt != 0) errEdge = e;
        frameCnt = 0;
      end
      slotRe[frameCnt] = re;
      slotIm[frameCnt] = im;
      frameCnt++;
      if (frameCnt == N) begin
        for (int k = 0; k < N; k++)
          expQ.push_back('{re: slotRe[revBits(k)], im: slotIm[revBits(k)], idx: k, at: e + 2 + k});
        frameCnt = 0;
      end
    end
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    frameCnt = 0;
    expQ.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int budget = 40;
    while (expQ.size() != 0 && budget > 0) begin
      applyStimulus(1'b0, 0, 0);
      budget--;
    end
    applyStimulus(1'b0, 0, 0);
    applyStimulus(1'b0, 0, 0);
    checkOutput("drain_empty", expQ.size(), 0);
  endtask

  function automatic int randSample();
    logic signed [W-1:0] s;
    s = W'($urandom);
    return int'(s);
  endfunction

  always @(negedge clk) begin
    exp_t x;
    if (!rst_n) begin
      checkOutput("rst_valid", out_valid, 0);
      checkOutput("rst_xr", X_r, 0);
      checkOutput("rst_xi", X_i, 0);
      checkOutput("rst_idx", out_idx, 0);
      checkOutput("rst_sof", out_sof, 0);
      lastRe = 0;
      lastIm = 0;
      lastIdx = 0;
    end else if (out_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("spurious_valid", 1, 0);
      end else begin
        x = expQ.pop_front();
        checkOutput("out_time", cyc, x.at);
        checkOutput("out_xr", X_r, x.re);
        checkOutput("out_xi", X_i, x.im);
        checkOutput("out_idx", out_idx, x.idx);
        checkOutput("out_sof", out_sof, x.idx == 0);
        lastRe = x.re;
        lastIm = x.im;
        lastIdx = x.idx;
      end
    end else begin
      checkOutput("hold_xr", X_r, lastRe);
      checkOutput("hold_xi", X_i, lastIm);
      checkOutput("hold_idx", out_idx, lastIdx);
      checkOutput("idle_sof", out_sof, 0);
    end
`ifdef FFT_REORDER_SOF_EN
    if (rst_n) checkOutput("error_drop", error_drop, cyc == errEdge);
`endif
  end

  initial begin
    int ref0[N] = '{0, 40, 20, 60, 10, 50, 30, 70};
    $display("[TB] start");
    doReset();

    // Single frame from the plan: bit-reversed arrival of 0..70
    for (int i = 0; i < N; i++) applyStimulus(1'b1, ref0[i], -ref0[i]);
    drain();

    // Three back-to-back frames, continuous valid
    for (int i = 0; i < 3 * N; i++) applyStimulus(1'b1, randSample(), randSample());
    drain();

    // Gapped frame of -8..-1
    for (int i = 0; i < N; i++) begin
      applyStimulus(1'b1, i - 8, 3 * i);
      applyStimulus(1'b0, 0, 0);
    end
    drain();

    // Reset after a partial frame, then one clean frame
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, randSample(), randSample());
    doReset();
    for (int i = 0; i < N; i++) applyStimulus(1'b1, 100 + i, -100 - i);
    drain();

    // Reset while a readout is in flight
    for (int i = 0; i < N + 3; i++) applyStimulus(1'b1, randSample(), randSample());
    doReset();
    for (int i = 0; i < N; i++) applyStimulus(1'b1, randSample(), randSample());
    drain();

    // Full-scale extremes
    for (int i = 0; i < N; i++) applyStimulus(1'b1, -2048, 2047);
    drain();

`ifdef FFT_REORDER_SOF_EN
    // Partial frame dropped by a resync, then a clean frame
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 900 + i, 0);
    for (int i = 0; i < N; i++) applyStimulus(1'b1, 200 + i, -i, i == 0);
    drain();
    // Resync on a boundary is silent
    for (int i = 0; i < N; i++) applyStimulus(1'b1, randSample(), randSample(), i == 0);
    drain();
`endif

    // Random valid pattern with random data
    for (int i = 0; i < 120; i++)
      applyStimulus($urandom_range(0, 3) != 0, randSample(), randSample());
    while (frameCnt != 0) applyStimulus(1'b1, randSample(), randSample());
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
- Output-reordering stage placed directly downstream of the final radix-2 SDF stage (fft_2) of the 8-point pipeline.
- The SDF chain emits X[k] in bit-reversed order. This block captures each frame into a ping-pong buffer and replays it in natural order X[0]..X[N-1].
- Each output sample carries a valid strobe and its bin index.

Parameters:
- N, 8, FFT length; power of two, >=4
- LOG2N, 3, log2(N); width of index counters
- W, 12, sample width (signed two's complement) per real/imag component

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  x_r/x_i carry one bit-reversed-order FFT sample this cycle
- x_r  in  W  signed real part from fft_2
- x_i  in  W  signed imaginary part from fft_2
- X_r  out  W  signed real part, natural order
- X_i  out  W  signed imaginary part, natural order
- out_valid  out  1  X_r/X_i/out_idx valid this cycle
- out_idx  out  LOG2N  bin index k of current output
- out_sof  out  1  high with out_valid when out_idx==0

Behaviour:
- Reset (async, rst_n=0): X_r=0, X_i=0, out_valid=0, out_idx=0, out_sof=0; wr_cnt=0, wr_bank=0, rd_cnt=0, state=IDLE. Buffer contents are don't-care. Release is synchronous to clk.
- Storage: 2 banks x N entries x 2W bits (registers or inferred RAM with a registered read).
- Write side:
  - On in_valid: write {x_r,x_i} to bank[wr_bank] at address bitrev(wr_cnt), then wr_cnt++.
  - When wr_cnt==N-1 on a valid cycle: wr_cnt wraps to 0, wr_bank toggles, and full_pulse asserts for one cycle carrying the completed bank id.
  - in_valid gaps are allowed and hold wr_cnt unchanged.
- Read FSM:
  - IDLE: on full_pulse, rd_bank := completed bank, rd_cnt := 0, go to READ.
  - READ: each cycle read bank[rd_bank][rd_cnt] and rd_cnt++. When rd_cnt==N-1, return to IDLE. If full_pulse arrives in the same cycle, go directly back to READ for the new bank with no gap.
- Output timing:
  - Outputs are registered, one sample per cycle for N consecutive cycles. Output pipeline latency is 1 cycle.
  - X[0] appears 2 cycles after the clock edge that writes the last (N-th) sample of a frame.
  - Continuous in_valid produces continuous out_valid after the initial fill latency.
- No-collision guarantee: filling a bank takes >=N cycles and reading takes exactly N cycles, so the writer never overwrites the bank under read. No backpressure is needed.
- When out_valid=0: X_r/X_i hold their last values, out_idx holds, out_sof=0.
- Arithmetic: pass-through only, no scaling. Bit widths are preserved exactly (W in, W out).
- bitrev(a): reverses the LOG2N bits of a. For N=8 the arrival slot to bin mapping is 0,4,2,6,1,5,3,7.
- Reset mid-frame: the partial frame and any in-progress readout are discarded. The first valid sample after reset is treated as slot 0.
- Simultaneous write-bank wrap and read start: permitted. The write goes to the new bank and the read uses the old bank.

Optional Feature:
- Macro: FFT_REORDER_SOF_EN
- Defined:
  - Adds input port in_sof (1 bit), qualified by in_valid.
  - When in_valid && in_sof: the sample is written at slot 0 of the current wr_bank and wr_cnt := 1.
  - A partial frame in that bank is discarded (no full_pulse) and error_drop pulses high for one cycle. error_drop is an added output port, reset value 0.
  - in_sof on a frame boundary (wr_cnt==0) is normal and raises no error.
- Undefined: no in_sof or error_drop ports; framing is purely by counting valid samples from reset.

Test Plan:
- Single frame: 8 consecutive in_valid with x_r=0,40,20,60,10,50,30,70 and x_i=-x_r -> X_r=0,10,...,70 and X_i=0,-10,...,-70 on 8 consecutive out_valid cycles. out_idx=0..7, out_sof only at idx 0, first output 2 cycles after the last input.
- Back-to-back: 3 frames with continuous in_valid -> 24 contiguous out_valid cycles in natural order per frame, no gaps and no bank corruption.
- Gapped input: in_valid toggling 1,0,1,0 across a frame of values -8..-1 -> output starts 2 cycles after the 8th valid and runs 8 contiguous cycles; outputs hold during idle.
- Reset mid-frame: rst_n low after 5 samples, then a full 8-sample frame -> out_valid=0 throughout reset, then exactly 8 outputs from the new frame only.
- Extremes: x_r=-2048, x_i=2047 in every slot -> identical values out, no sign loss.
- FFT_REORDER_SOF_EN: 3 samples, then in_sof with a full 8-sample frame -> error_drop one pulse, one correct natural-order frame out, the partial frame never output.
